// File: rtl/sap1_loader.sv
// SAP-1 program loader and run controller: streams bytes into the 16x8 program RAM,
// optionally pads the rest with a halt opcode, holds the CPU in clear, then releases it.
module sap1_loader #(
  parameter int unsigned CLR_CYCLES = 2,
  parameter bit          FILL_EN    = 1'b1,
  parameter logic [7:0]  FILL_BYTE  = 8'hF0
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       load,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       in_ready,
  output logic       prog,
  output logic       write,
  output logic [3:0] a,
  output logic [7:0] d,
  output logic       cpu_clr,
  output logic       cpu_run,
  output logic       busy,
  output logic [4:0] count
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StWrite,
    StFill,
    StClear,
    StRun
  } state_e;

  localparam logic [3:0] ClrLast = 4'(CLR_CYCLES - 1);

  state_e     state_q, state_d;
  logic [4:0] ptr_q, ptr_d;
  logic [4:0] ptr_inc;
  logic [4:0] count_q, count_d;
  logic [7:0] d_q, d_d;
  logic       last_q, last_d;
  logic [3:0] clr_cnt_q, clr_cnt_d;

  logic       in_ready_q;
  logic       prog_q;
  logic       write_q;
  logic       cpu_clr_q;
  logic       cpu_run_q;
  logic       busy_q;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    count_d   = count_q;
    d_d       = d_q;
    last_d    = last_q;
    clr_cnt_d = clr_cnt_q;
    ptr_inc   = ptr_q + 5'd1;

    unique case (state_q)
      StIdle, StRun: begin
        if (load) begin
          state_d = StLoad;
          ptr_d   = 5'd0;
          count_d = 5'd0;
        end
      end
      StLoad: begin
        if (in_valid && in_ready_q) begin
          d_d     = in_data;
          last_d  = in_last;
          count_d = count_q + 5'd1;
          state_d = StWrite;
        end
      end
      StWrite: begin
        ptr_d = ptr_inc;
        // The 16th byte terminates the stream even without in_last.
        if (last_q || (ptr_inc == 5'd16)) begin
          if (FILL_EN && (ptr_inc < 5'd16)) begin
            state_d = StFill;
            d_d     = FILL_BYTE;
          end else begin
            state_d   = StClear;
            clr_cnt_d = 4'd0;
          end
        end else begin
          state_d = StLoad;
        end
      end
      StFill: begin
        ptr_d = ptr_inc;
        if (ptr_inc == 5'd16) begin
          state_d   = StClear;
          clr_cnt_d = 4'd0;
        end
      end
      StClear: begin
        if (clr_cnt_q == ClrLast) begin
          state_d = StRun;
        end else begin
          clr_cnt_d = clr_cnt_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so every pin comes straight off a flop.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= StIdle;
      ptr_q      <= 5'd0;
      count_q    <= 5'd0;
      d_q        <= 8'd0;
      last_q     <= 1'b0;
      clr_cnt_q  <= 4'd0;
      in_ready_q <= 1'b0;
      prog_q     <= 1'b0;
      write_q    <= 1'b0;
      cpu_clr_q  <= 1'b1;
      cpu_run_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      count_q    <= count_d;
      d_q        <= d_d;
      last_q     <= last_d;
      clr_cnt_q  <= clr_cnt_d;
      in_ready_q <= (state_d == StLoad);
      prog_q     <= (state_d == StLoad) || (state_d == StWrite) || (state_d == StFill);
      write_q    <= (state_d == StWrite) || (state_d == StFill);
      cpu_clr_q  <= (state_d != StRun);
      cpu_run_q  <= (state_d == StRun);
      busy_q     <= (state_d == StLoad) || (state_d == StWrite) || (state_d == StFill) ||
                    (state_d == StClear);
    end
  end

  assign in_ready = in_ready_q;
  assign prog     = prog_q;
  assign write    = write_q;
  assign a        = ptr_q[3:0];
  assign d        = d_q;
  assign cpu_clr  = cpu_clr_q;
  assign cpu_run  = cpu_run_q;
  assign busy     = busy_q;
  assign count    = count_q;

endmodule

// File: tb/tb_sap1_loader.sv
// Directed bench for sap1_loader: one instance with fill enabled, one with fill disabled.
module tb_sap1_loader;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       load = 1'b0;
  logic       load_nf = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       in_last = 1'b0;

  logic       in_ready, prog, write, cpu_clr, cpu_run, busy;
  logic [3:0] a;
  logic [7:0] d;
  logic [4:0] count;

  logic       nf_in_ready, nf_prog, nf_write, nf_cpu_clr, nf_cpu_run, nf_busy;
  logic [3:0] nf_a;
  logic [7:0] nf_d;
  logic [4:0] nf_count;

  int n_checks = 0;
  int n_errors = 0;

  logic [11:0] wq[$];
  logic [11:0] nq[$];
  int          clear_cycles = 0;

  logic [7:0] p2 [0:5] = '{8'h09, 8'h1A, 8'h1B, 8'h2C, 8'hE0, 8'hF0};
  logic [7:0] p4 [0:2] = '{8'h31, 8'h42, 8'h53};

  always #5 clk = ~clk;

  sap1_loader #(.CLR_CYCLES(2), .FILL_EN(1'b1), .FILL_BYTE(8'hF0)) dut (
    .clk(clk), .clr(clr), .load(load), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .prog(prog), .write(write), .a(a), .d(d),
    .cpu_clr(cpu_clr), .cpu_run(cpu_run), .busy(busy), .count(count)
  );

  sap1_loader #(.CLR_CYCLES(2), .FILL_EN(1'b0), .FILL_BYTE(8'hF0)) dut_nf (
    .clk(clk), .clr(clr), .load(load_nf), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(nf_in_ready), .prog(nf_prog), .write(nf_write), .a(nf_a),
    .d(nf_d), .cpu_clr(nf_cpu_clr), .cpu_run(nf_cpu_run), .busy(nf_busy), .count(nf_count)
  );

  // Observe RAM write port and CLEAR-state occupancy away from the active edge.
  always @(negedge clk) begin
    if (write) wq.push_back({a, d});
    if (nf_write) nq.push_back({nf_a, nf_d});
    if (busy && !prog) clear_cycles++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic rdy(input int sel);
    return (sel == 0) ? in_ready : nf_in_ready;
  endfunction

  function automatic logic running(input int sel);
    return (sel == 0) ? cpu_run : nf_cpu_run;
  endfunction

  task automatic pulse_load(input int sel);
    if (sel == 0) load = 1'b1; else load_nf = 1'b1;
    tick();
    load    = 1'b0;
    load_nf = 1'b0;
  endtask

  // Returns just after the accepting edge.
  task automatic send(input int sel, input logic [7:0] b, input logic l);
    int n = 0;
    in_valid = 1'b1;
    in_data  = b;
    in_last  = l;
    while (!rdy(sel) && n < 50) begin
      tick();
      n++;
    end
    if (!rdy(sel)) check("send_timeout", 32'd0, 32'd1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_run(input int sel, output int cycles, output bit saw_ready);
    cycles    = 0;
    saw_ready = 1'b0;
    while (!running(sel) && cycles < 100) begin
      if (rdy(sel)) saw_ready = 1'b1;
      tick();
      cycles++;
    end
    if (!running(sel)) check("run_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int  cyc;
    bit  sr;
    int  base;
    int  cbase;
    logic [7:0] e;

    // Reset and one idle cycle.
    #12;
    clr = 1'b0;
    tick();
    check("rst_cpu_clr", cpu_clr, 1);
    check("rst_cpu_run", cpu_run, 0);
    check("rst_prog", prog, 0);
    check("rst_write", write, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_count", count, 0);
    check("rst_busy", busy, 0);

    // Six-byte program with fill.
    pulse_load(0);
    check("load_in_ready", in_ready, 1);
    check("load_prog", prog, 1);
    check("load_busy", busy, 1);
    base  = wq.size();
    cbase = clear_cycles;
    for (int i = 0; i < 6; i++) send(0, p2[i], i == 5);
    wait_run(0, cyc, sr);
    check("p2_cycles", cyc, 13);
    check("p2_clear_cycles", clear_cycles - cbase, 2);
    check("p2_nwrites", wq.size() - base, 16);
    for (int i = 0; i < 16; i++) begin
      e = (i < 6) ? p2[i] : 8'hF0;
      check($sformatf("p2_w%0d", i), wq[base + i], {i[3:0], e});
    end
    check("p2_count", count, 6);
    check("p2_run_cpu_clr", cpu_clr, 0);
    check("p2_run_busy", busy, 0);

    // Load from RUN, then a full 16-byte stream without in_last.
    pulse_load(0);
    check("rl_cpu_run", cpu_run, 0);
    check("rl_cpu_clr", cpu_clr, 1);
    check("rl_in_ready", in_ready, 1);
    check("rl_count", count, 0);
    base = wq.size();
    for (int i = 0; i < 16; i++) send(0, 8'h80 + 8'(i), 1'b0);
    in_valid = 1'b1;
    in_data  = 8'hAA;
    wait_run(0, cyc, sr);
    check("f16_cycles", cyc, 3);
    check("f16_ready_after_last", sr, 0);
    tick();
    in_valid = 1'b0;
    check("f16_nwrites", wq.size() - base, 16);
    for (int i = 0; i < 16; i++)
      check($sformatf("f16_w%0d", i), wq[base + i], {i[3:0], 8'h80 + 8'(i)});
    check("f16_count", count, 16);

    // Gapped valid: 1,0,0,1 pattern between bytes.
    pulse_load(0);
    base = wq.size();
    send(0, p4[0], 1'b0);
    tick();
    tick();
    check("gap_in_ready", in_ready, 1);
    check("gap_cpu_clr", cpu_clr, 1);
    check("gap_write", write, 0);
    send(0, p4[1], 1'b0);
    tick();
    tick();
    send(0, p4[2], 1'b1);
    wait_run(0, cyc, sr);
    check("gap_cycles", cyc, 16);
    check("gap_nwrites", wq.size() - base, 16);
    for (int i = 0; i < 16; i++) begin
      e = (i < 3) ? p4[i] : 8'hF0;
      check($sformatf("gap_w%0d", i), wq[base + i], {i[3:0], e});
    end
    check("gap_count", count, 3);

    // Asynchronous clr during FILL at ptr 9.
    pulse_load(0);
    send(0, 8'h11, 1'b0);
    send(0, 8'h22, 1'b1);
    cyc = 0;
    while (!(write && a == 4'd9) && cyc < 50) begin
      tick();
      cyc++;
    end
    check("fill_reach_9", {write, a}, {1'b1, 4'd9});
    #2;
    clr = 1'b1;
    #1;
    check("aclr_write", write, 0);
    check("aclr_prog", prog, 0);
    check("aclr_cpu_clr", cpu_clr, 1);
    check("aclr_cpu_run", cpu_run, 0);
    check("aclr_in_ready", in_ready, 0);
    check("aclr_busy", busy, 0);
    check("aclr_count", count, 0);
    check("aclr_a", a, 0);
    check("aclr_d", d, 0);
    tick();
    clr = 1'b0;
    tick();
    pulse_load(0);
    check("reload_count", count, 0);
    check("reload_in_ready", in_ready, 1);
    base = wq.size();
    send(0, 8'h77, 1'b1);
    wait_run(0, cyc, sr);
    check("reload_w0", wq[base], {4'd0, 8'h77});
    check("reload_nwrites", wq.size() - base, 16);
    check("reload_count1", count, 1);

    // FILL_EN=0 instance: first run, then load from RUN with a single HLT byte.
    pulse_load(1);
    send(1, 8'hE0, 1'b1);
    wait_run(1, cyc, sr);
    check("nf1_cycles", cyc, 3);
    pulse_load(1);
    check("nf_rl_cpu_run", nf_cpu_run, 0);
    check("nf_rl_in_ready", nf_in_ready, 1);
    base = nq.size();
    send(1, 8'hE0, 1'b1);
    wait_run(1, cyc, sr);
    check("nf_cycles", cyc, 3);
    check("nf_nwrites", nq.size() - base, 1);
    check("nf_w0", nq[base], {4'd0, 8'hE0});
    check("nf_count", nf_count, 1);
    check("nf_run_cpu_clr", nf_cpu_clr, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
